bus_slave_port: RTL and testbench

Serial slave endpoint that sits directly downstream of the bus controller's slave-select and serial address/data muxes. It deserialises address and write data, performs the access on a local memory, serialises read data back, and generates the `ready`, `response` and `split` signals that the controller consumes to end, hold or fail a transfer. One instance is placed per slave (slave 1, slave 2).

---
 rtl/bus_pkg.sv | 26 ++
 rtl/bus_slave_port_if.sv | 29 ++
 rtl/bus_slave_port_mem.sv | 25 ++
 rtl/bus_slave_port.sv | 199 +++++++++++++++++++
 tb/tb_bus_slave_port.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: response encodings, FSM states and helpers
// shared by the serial slave endpoint files.
package bus_pkg;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;
    localparam logic [1:0] RESP_SPLIT = 2'b10;
    localparam logic [1:0] RESP_BUSY  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        WAIT,
        RDATA,
        DONE,
        ERR
    } state_e;

    function automatic int max3(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bus_slave_port_if.sv
// bus_slave_port_if: serial controller <-> slave signals.
// master = bus controller side, slave = endpoint side.
interface bus_slave_port_if;

    logic       sel;
    logic       read_write;
    logic       addr_in;
    logic       addr_valid;
    logic       wdata_in;
    logic       wdata_valid;
    logic       rdata_out;
    logic       rdata_valid;
    logic       ready;
    logic [1:0] response;
    logic       split;

    modport master (
        output sel, read_write, addr_in, addr_valid,
        output wdata_in, wdata_valid,
        input  rdata_out, rdata_valid, ready, response, split
    );

    modport slave (
        input  sel, read_write, addr_in, addr_valid,
        input  wdata_in, wdata_valid,
        output rdata_out, rdata_valid, ready, response, split
    );

endinterface

// File: rtl/bus_slave_port_mem.sv
// slave_mem: local word store of the slave endpoint,
// synchronous write and asynchronous read, not reset.
module slave_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 2048,
    localparam int MAW       = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [MAW-1:0]        waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [MAW-1:0]        raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Write port: one word per enabled edge.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bus_slave_port.sv
// bus_slave_port: serial slave endpoint (address/data shift-in,
// local memory access, serial read-out). Macro BUS_SLAVE_SPLIT_EN.
module bus_slave_port
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH    = 12,
    parameter int DATA_WIDTH    = 8,
    parameter int MEM_DEPTH     = 2048,
    parameter int SPLIT_BASE    = 1024,
    parameter int SPLIT_LATENCY = 4
) (
    input logic             clk,
    input logic             rst,
    bus_slave_port_if.slave bus
);

    localparam int MAW = $clog2(MEM_DEPTH);
    localparam int CW  =
        $clog2(max3(ADDR_WIDTH, DATA_WIDTH, SPLIT_LATENCY) + 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_L = MEM_DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] SPLIT_L = SPLIT_BASE[ADDR_WIDTH:0];

`ifdef BUS_SLAVE_SPLIT_EN
    localparam bit SPLIT_ON = 1'b1;
`else
    localparam bit SPLIT_ON = 1'b0;
`endif

    state_e                state, state_n;
    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-1:0] addr_sh, addr_full, cur_addr;
    logic [DATA_WIDTH-2:0] wsh;
    logic [DATA_WIDTH-1:0] wword, rword, rsh;
    logic                  wr, load, we, adv;
    logic                  addr_last, data_last, wait_last, rd_last;
    logic                  is_err, is_slow;
    logic                  ready_n, split_n;
    logic [1:0]            resp_n;

    assign addr_full = {addr_sh[ADDR_WIDTH-2:0], bus.addr_in};
    // While waiting, the address is complete in the shifter.
    assign cur_addr  = (state == WAIT) ? addr_sh : addr_full;
    assign wword     = {wsh, bus.wdata_in};

    assign is_err  = {1'b0, cur_addr} >= DEPTH_L;
    assign is_slow = {1'b0, cur_addr} >= SPLIT_L;

    assign addr_last = bus.addr_valid &&
                       (cnt == CW'(ADDR_WIDTH - 1));
    assign data_last = bus.wdata_valid &&
                       (cnt == CW'(DATA_WIDTH - 1));
    assign wait_last = cnt == CW'(SPLIT_LATENCY - 1);
    assign rd_last   = cnt == CW'(DATA_WIDTH - 1);

    slave_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (addr_sh[MAW-1:0]),
        .wdata (wword),
        .raddr (cur_addr[MAW-1:0]),
        .rdata (rword)
    );

    // Next state; dropping sel outranks every other transition.
    always_comb begin
        state_n = state;
        load    = 1'b0;
        we      = 1'b0;
        adv     = 1'b0;
        if (state != IDLE && !bus.sel) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.sel && bus.addr_valid) state_n = ADDR;
                end
                ADDR: begin
                    adv = bus.addr_valid;
                    if (addr_last) begin
                        if (is_err) begin
                            state_n = ERR;
                        end else if (wr) begin
                            state_n = WDATA;
                        end else if (is_slow) begin
                            state_n = WAIT;
                        end else begin
                            state_n = RDATA;
                            load    = 1'b1;
                        end
                    end
                end
                WDATA: begin
                    adv = bus.wdata_valid;
                    if (data_last) begin
                        state_n = DONE;
                        we      = 1'b1;
                    end
                end
                WAIT: begin
                    adv = 1'b1;
                    if (wait_last) begin
                        state_n = RDATA;
                        load    = 1'b1;
                    end
                end
                RDATA: begin
                    adv = 1'b1;
                    if (rd_last) state_n = DONE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Output values for the state being entered.
    always_comb begin
        ready_n = 1'b0;
        resp_n  = RESP_BUSY;
        split_n = 1'b0;
        unique case (state_n)
            IDLE, DONE: begin
                ready_n = 1'b1;
                resp_n  = RESP_OKAY;
            end
            ERR: begin
                ready_n = 1'b1;
                resp_n  = RESP_ERROR;
            end
            WAIT: begin
                split_n = SPLIT_ON;
                resp_n  = SPLIT_ON ? RESP_SPLIT : RESP_BUSY;
            end
            default: resp_n = RESP_BUSY;
        endcase
    end

    // FSM, counter and shift registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_sh <= '0;
            wsh     <= '0;
            rsh     <= '0;
            wr      <= 1'b0;
        end else begin
            state <= state_n;
            if (state_n != state)
                cnt <= (state == IDLE) ? CW'(1) : '0;
            else if (adv)
                cnt <= cnt + CW'(1);
            if ((state == IDLE && state_n == ADDR) ||
                (state == ADDR && bus.addr_valid))
                addr_sh <= addr_full;
            if (state == IDLE && state_n == ADDR)
                wr <= bus.read_write;
            if (state == WDATA && bus.wdata_valid)
                wsh <= wword[DATA_WIDTH-2:0];
            if (load)
                rsh <= {rword[DATA_WIDTH-2:0], 1'b0};
            else if (state == RDATA)
                rsh <= {rsh[DATA_WIDTH-2:0], 1'b0};
        end
    end

    // Registered bus outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ready       <= 1'b1;
            bus.response    <= RESP_OKAY;
            bus.rdata_valid <= 1'b0;
            bus.rdata_out   <= 1'b0;
        end else begin
            bus.ready       <= ready_n;
            bus.response    <= resp_n;
            bus.rdata_valid <= state_n == RDATA;
            if (load)
                bus.rdata_out <= rword[DATA_WIDTH-1];
            else if (state == RDATA && state_n == RDATA)
                bus.rdata_out <= rsh[DATA_WIDTH-1];
            else
                bus.rdata_out <= 1'b0;
        end
    end

`ifdef BUS_SLAVE_SPLIT_EN
    // Split flag mirrors occupancy of the wait state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.split <= 1'b0;
        else     bus.split <= split_n;
    end
`else
    assign bus.split = 1'b0;
`endif

endmodule

// File: tb/tb_bus_slave_port.sv
// tb_bus_slave_port: directed and random serial transfers checked
// every cycle against a transfer-level model with a reference memory.
module tb_bus_slave_port;

    localparam int K_IDLE = 0;
    localparam int K_BUSY = 1;
    localparam int K_WAIT = 2;
    localparam int K_RD   = 3;
    localparam int K_ERR  = 4;

`ifdef BUS_SLAVE_SPLIT_EN
    localparam bit SPL = 1'b1;
`else
    localparam bit SPL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    bus_slave_port_if bus ();

    bus_slave_port #(
        .ADDR_WIDTH    (12),
        .DATA_WIDTH    (8),
        .MEM_DEPTH     (2048),
        .SPLIT_BASE    (1024),
        .SPLIT_LATENCY (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         nvec = 0;
    int         nerr = 0;
    int         cyc_no = 0;
    int         t0 = 0;
    int         done_at = -1;
    int         n_split = 0;
    int         n_r10 = 0;
    bit         chk_en = 1'b0;
    bit         prev_ready = 1'b1;
    logic [7:0] got = '0;

    bit         e_ready, e_split, e_rv, e_rd, e_rk;
    logic [1:0] e_resp;

    logic [7:0] ref_mem [2048];
    bit         known [2048];

    task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc_no - t0);
        end
    endtask

    // Per-cycle compare against the expected output set.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", 8'(bus.ready), 8'(e_ready));
            chk("response", 8'(bus.response), 8'(e_resp));
            chk("split", 8'(bus.split), 8'(e_split));
            chk("rdata_valid", 8'(bus.rdata_valid), 8'(e_rv));
            if (e_rv && e_rk)
                chk("rdata_out", 8'(bus.rdata_out), 8'(e_rd));
        end
        if (!prev_ready && bus.ready === 1'b1) done_at = cyc_no - t0;
        prev_ready = bus.ready;
        if (bus.rdata_valid === 1'b1) got = {got[6:0], bus.rdata_out};
        if (bus.split === 1'b1) n_split++;
        if (bus.response === 2'b10) n_r10++;
    end

    task automatic e_set(int k, bit rd, bit rk);
        e_ready = (k == K_IDLE) || (k == K_ERR);
        e_split = (k == K_WAIT) && SPL;
        e_rv    = (k == K_RD);
        e_rd    = rd;
        e_rk    = rk;
        case (k)
            K_IDLE:  e_resp = 2'b00;
            K_ERR:   e_resp = 2'b01;
            K_WAIT:  e_resp = SPL ? 2'b10 : 2'b11;
            default: e_resp = 2'b11;
        endcase
    endtask

    task automatic cyc(bit s, bit av, bit a, bit wv, bit w,
                       int k, bit rd, bit rk);
        bus.sel         = s;
        bus.read_write  = bit'($urandom);
        bus.addr_valid  = av;
        bus.addr_in     = a;
        bus.wdata_valid = wv;
        bus.wdata_in    = w;
        e_set(k, rd, rk);
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    // One transfer; abort = bits done before sel drops (-1 none),
    // rst_at = read bits streamed before a reset pulse (-1 none).
    task automatic xfer(bit rw, logic [11:0] a, logic [7:0] d,
                        int ast, int dst, int abort, int rst_at);
        int   rem, n;
        bit   err, slow, kn;
        logic [7:0] cur;
        err  = int'(a) >= 2048;
        slow = int'(a) >= 1024;
        kn   = !err && known[a[10:0]];
        cur  = err ? 8'h00 : ref_mem[a[10:0]];
        t0   = cyc_no;
        bus.sel         = 1'b1;
        bus.read_write  = rw;
        bus.addr_valid  = 1'b1;
        bus.addr_in     = a[11];
        bus.wdata_valid = bit'($urandom);
        bus.wdata_in    = bit'($urandom);
        e_set(K_IDLE, 0, 0);
        @(posedge clk);
        #1;
        cyc_no++;
        rem = ast;
        for (int i = 10; i >= 0; i--) begin
            n = (i == 0) ? rem : int'($urandom_range(rem, 0));
            repeat (n) cyc(1, 0, bit'($urandom), bit'($urandom),
                           bit'($urandom), K_BUSY, 0, 0);
            rem -= n;
            cyc(1, 1, a[i], bit'($urandom), bit'($urandom),
                K_BUSY, 0, 0);
        end
        if (err) begin
            cyc(1, 1, bit'($urandom), 0, 0, K_ERR, 0, 0);
            return;
        end
        if (rw) begin
            rem = dst;
            for (int i = 7; i >= 0; i--) begin
                n = (i == 0) ? rem : int'($urandom_range(rem, 0));
                repeat (n) cyc(1, bit'($urandom), bit'($urandom), 0,
                               bit'($urandom), K_BUSY, 0, 0);
                rem -= n;
                if (abort == 7 - i) begin
                    cyc(0, 0, 0, 1, d[i], K_BUSY, 0, 0);
                    return;
                end
                cyc(1, bit'($urandom), bit'($urandom), 1, d[i],
                    K_BUSY, 0, 0);
            end
            ref_mem[a[10:0]] = d;
            known[a[10:0]]   = 1'b1;
            cyc(1, 1, bit'($urandom), 0, 0, K_IDLE, 0, 0);
            return;
        end
        if (slow)
            repeat (4) cyc(1, bit'($urandom), bit'($urandom),
                           bit'($urandom), 0, K_WAIT, 0, 0);
        for (int i = 7; i >= 0; i--) begin
            if (rst_at == 7 - i) begin
                e_set(K_IDLE, 0, 0);
                rst = 1'b1;
                #1;
                chk("rst_ready", 8'(bus.ready), 8'd1);
                chk("rst_resp", 8'(bus.response), 8'd0);
                chk("rst_split", 8'(bus.split), 8'd0);
                chk("rst_rvalid", 8'(bus.rdata_valid), 8'd0);
                @(posedge clk);
                #1;
                cyc_no++;
                rst = 1'b0;
                return;
            end
            if (abort == 7 - i) begin
                cyc(0, 0, 0, 0, 0, K_RD, cur[i], kn);
                return;
            end
            cyc(1, bit'($urandom), bit'($urandom), bit'($urandom),
                0, K_RD, cur[i], kn);
        end
        cyc(1, 1, bit'($urandom), 0, 0, K_IDLE, 0, 0);
    endtask

    logic [11:0] pool [10];

    initial begin
        bus.sel         = 1'b0;
        bus.read_write  = 1'b0;
        bus.addr_in     = 1'b0;
        bus.addr_valid  = 1'b0;
        bus.wdata_in    = 1'b0;
        bus.wdata_valid = 1'b0;
        for (int i = 0; i < 2048; i++) known[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_ready", 8'(bus.ready), 8'd1);
        chk("init_resp", 8'(bus.response), 8'd0);
        chk("init_split", 8'(bus.split), 8'd0);
        chk("init_rvalid", 8'(bus.rdata_valid), 8'd0);
        chk("init_rdata", 8'(bus.rdata_out), 8'd0);
        rst = 1'b0;
        e_set(K_IDLE, 0, 0);
        chk_en = 1'b1;
        cyc(0, 0, 0, 0, 0, K_IDLE, 0, 0);

        xfer(1, 12'h010, 8'hA5, 0, 0, -1, -1);
        chk("wr_done_cycle", 8'(done_at), 8'd20);
        got = '0;
        xfer(0, 12'h010, 8'h00, 0, 0, -1, -1);
        chk("rd_done_cycle", 8'(done_at), 8'd20);
        chk("rd_word_010", got, 8'hA5);

        xfer(1, 12'h020, 8'h3C, 2, 3, -1, -1);
        chk("stall_done_cycle", 8'(done_at), 8'd25);
        got = '0;
        xfer(0, 12'h020, 8'h00, 1, 0, -1, -1);
        chk("rd_word_020", got, 8'h3C);

        xfer(1, 12'h100, 8'h5A, 0, 0, -1, -1);
        xfer(0, 12'h900, 8'h00, 0, 0, -1, -1);
        chk("err_cycle", 8'(done_at), 8'd12);
        xfer(1, 12'h900, 8'hFF, 0, 0, -1, -1);
        got = '0;
        xfer(0, 12'h100, 8'h00, 0, 0, -1, -1);
        chk("rd_word_100", got, 8'h5A);

        xfer(1, 12'h400, 8'hC3, 0, 0, -1, -1);
        got     = '0;
        n_split = 0;
        n_r10   = 0;
        xfer(0, 12'h400, 8'h00, 0, 0, -1, -1);
        chk("slow_done_cycle", 8'(done_at), 8'd24);
        chk("rd_word_400", got, 8'hC3);
        chk("split_cycles", 8'(n_split), SPL ? 8'd4 : 8'd0);
        chk("resp10_cycles", 8'(n_r10), SPL ? 8'd4 : 8'd0);

        xfer(1, 12'h030, 8'h11, 0, 0, -1, -1);
        xfer(1, 12'h030, 8'hEE, 0, 0, 6, -1);
        got = '0;
        xfer(0, 12'h030, 8'h00, 0, 0, -1, -1);
        chk("rd_word_030", got, 8'h11);

        xfer(0, 12'h010, 8'h00, 0, 0, -1, 3);
        got = '0;
        xfer(0, 12'h010, 8'h00, 0, 0, -1, -1);
        chk("rd_after_rst", got, 8'hA5);

        for (int i = 0; i < 4; i++) pool[i] = 12'($urandom_range(1023, 0));
        for (int i = 4; i < 8; i++)
            pool[i] = 12'($urandom_range(2047, 1024));
        pool[8] = 12'($urandom_range(4095, 2048));
        pool[9] = 12'hFFF;
        for (int t = 0; t < 300; t++) begin
            xfer(bit'($urandom), pool[$urandom_range(9, 0)],
                 8'($urandom), int'($urandom_range(3, 0)),
                 int'($urandom_range(3, 0)),
                 ($urandom_range(7, 0) == 0) ?
                     int'($urandom_range(7, 0)) : -1,
                 -1);
            if ($urandom_range(3, 0) == 0)
                cyc(0, bit'($urandom), bit'($urandom), bit'($urandom),
                    bit'($urandom), K_IDLE, 0, 0);
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
